// File: rtl/button_event_decoder_if.sv
// Event-decoder bus: debounced button level in, press strobes and event count out.
// master = the side that drives btn_state; slave = the decoder.
interface button_event_decoder_if;
    localparam int unsigned EVT_W = 8;

    logic             btn_state;
    logic             short_press;
    logic             long_press;
    logic             repeat_press;
    logic             held;
    logic [EVT_W-1:0] evt_count;

    modport master (
        output btn_state,
        input  short_press,
        input  long_press,
        input  repeat_press,
        input  held,
        input  evt_count
    );

    modport slave (
        input  btn_state,
        output short_press,
        output long_press,
        output repeat_press,
        output held,
        output evt_count
    );
endinterface

// File: rtl/button_event_decoder.sv
// Classifies debounced button presses into short/long strobes plus an event count.
// Define BUTTON_EVENT_REPEAT_EN to emit auto-repeat strobes while a long press is held.
module button_event_decoder #(
    parameter int unsigned LONG_CYCLES   = 50_000_000,
    parameter int unsigned REPEAT_CYCLES = 10_000_000,
    parameter int unsigned CNT_W         = 27
) (
    input  logic                         clk,
    input  logic                         rst,
    button_event_decoder_if.slave        bus
);
    localparam int unsigned EVT_W = 8;

    // Elaboration-time parameter legality checks.
    if (LONG_CYCLES < 2) begin : g_bad_long
        $error("button_event_decoder: LONG_CYCLES must be >= 2");
    end
    if (REPEAT_CYCLES < 1) begin : g_bad_repeat
        $error("button_event_decoder: REPEAT_CYCLES must be >= 1");
    end
    if ((CNT_W < 64) &&
        (((64'(1) << CNT_W) <= 64'(LONG_CYCLES)) ||
         ((64'(1) << CNT_W) <= 64'(REPEAT_CYCLES)))) begin : g_bad_cnt_w
        $error("button_event_decoder: CNT_W too narrow for the cycle thresholds");
    end

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
`ifdef BUTTON_EVENT_REPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             prev_btn_q;
    logic             short_q;
    logic             long_q;
    logic             repeat_q;
    logic             held_q;
    logic [EVT_W-1:0] evt_q;
    logic             rise_c;

    assign rise_c = bus.btn_state & ~prev_btn_q;

    // prev_btn resets high so a button held through reset is ignored until re-pressed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            prev_btn_q <= 1'b1;
            short_q    <= 1'b0;
            long_q     <= 1'b0;
            repeat_q   <= 1'b0;
            held_q     <= 1'b0;
            evt_q      <= '0;
        end else begin
            prev_btn_q <= bus.btn_state;
            short_q    <= 1'b0;
            long_q     <= 1'b0;
            repeat_q   <= 1'b0;

            unique case (state_q)
                IDLE: begin
                    held_q <= 1'b0;
                    if (rise_c) begin
                        state_q <= PRESSED;
                        cnt_q   <= CNT_W'(1);
                        held_q  <= 1'b1;
                    end
                end
                PRESSED: begin
                    if (bus.btn_state) begin
                        if (cnt_q == LONG_LAST) begin
                            long_q  <= 1'b1;
                            state_q <= HELD;
                            cnt_q   <= '0;
                            evt_q   <= evt_q + EVT_W'(1);
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end else begin
                        short_q <= 1'b1;
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        held_q  <= 1'b0;
                        evt_q   <= evt_q + EVT_W'(1);
                    end
                end
                HELD: begin
                    if (bus.btn_state) begin
`ifdef BUTTON_EVENT_REPEAT_EN
                        if (cnt_q == REPEAT_LAST) begin
                            repeat_q <= 1'b1;
                            cnt_q    <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
`else
                        cnt_q <= '0;
`endif
                    end else begin
                        state_q <= IDLE;
                        held_q  <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    held_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.short_press  = short_q;
    assign bus.long_press   = long_q;
    assign bus.repeat_press = repeat_q;
    assign bus.held         = held_q;
    assign bus.evt_count    = evt_q;
endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with LONG_CYCLES=8, REPEAT_CYCLES=4.
// Repeat expectations follow BUTTON_EVENT_REPEAT_EN as defined for the build.
module tb_button_event_decoder;
    localparam int unsigned LONG_C = 8;
    localparam int unsigned REP_C  = 4;
    localparam int unsigned CW     = 4;

    logic clk;
    logic rst;

    button_event_decoder_if bus();

    button_event_decoder #(
        .LONG_CYCLES  (LONG_C),
        .REPEAT_CYCLES(REP_C),
        .CNT_W        (CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    int n_short, n_long, n_rep, last_long;
    int short_q[$];
    int rep_q[$];

    task automatic clear_mon();
        n_short = 0; n_long = 0; n_rep = 0; last_long = -1;
        short_q.delete();
        rep_q.delete();
    endtask

    // Drive one sample, then observe the outputs just after the edge that took it.
    task automatic cyc(input logic b);
        bus.btn_state = b;
        @(posedge clk);
        #1;
        cycle++;
        if (bus.short_press)  begin n_short++; short_q.push_back(cycle); end
        if (bus.long_press)   begin n_long++;  last_long = cycle; end
        if (bus.repeat_press) begin n_rep++;   rep_q.push_back(cycle); end
    endtask

    task automatic do_reset(input logic b);
        rst = 1'b1;
        cyc(b);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(1'b0);
        checks++; if (bus.short_press !== 1'b0)  begin errors++; $display("FAIL reset_short: got %b expected 0", bus.short_press); end
        checks++; if (bus.long_press !== 1'b0)   begin errors++; $display("FAIL reset_long: got %b expected 0", bus.long_press); end
        checks++; if (bus.repeat_press !== 1'b0) begin errors++; $display("FAIL reset_repeat: got %b expected 0", bus.repeat_press); end
        checks++; if (bus.held !== 1'b0)         begin errors++; $display("FAIL reset_held: got %b expected 0", bus.held); end
        checks++; if (bus.evt_count !== 8'd0)    begin errors++; $display("FAIL reset_evt: got %0d expected 0", bus.evt_count); end
        rst = 1'b0;
        cyc(1'b0);
    endtask

    task automatic test_short();
        do_reset(1'b0); cyc(1'b0); clear_mon();
        cyc(1'b1);
        checks++; if (bus.held !== 1'b1) begin errors++; $display("FAIL short_held_rise: got %b expected 1", bus.held); end
        cyc(1'b1); cyc(1'b1);
        checks++; if (bus.held !== 1'b1)        begin errors++; $display("FAIL short_held_3: got %b expected 1", bus.held); end
        checks++; if (bus.short_press !== 1'b0) begin errors++; $display("FAIL short_early: got %b expected 0", bus.short_press); end
        cyc(1'b0);
        checks++; if (bus.short_press !== 1'b1) begin errors++; $display("FAIL short_strobe: got %b expected 1", bus.short_press); end
        checks++; if (bus.long_press !== 1'b0)  begin errors++; $display("FAIL short_long: got %b expected 0", bus.long_press); end
        checks++; if (bus.held !== 1'b0)        begin errors++; $display("FAIL short_held_rel: got %b expected 0", bus.held); end
        checks++; if (bus.evt_count !== 8'd1)   begin errors++; $display("FAIL short_evt: got %0d expected 1", bus.evt_count); end
        cyc(1'b0);
        checks++; if (bus.short_press !== 1'b0) begin errors++; $display("FAIL short_one_cycle: got %b expected 0", bus.short_press); end
        checks++; if (n_short !== 1)            begin errors++; $display("FAIL short_count: got %0d expected 1", n_short); end
    endtask

    task automatic test_long_boundary();
        do_reset(1'b0); cyc(1'b0); clear_mon();
        repeat (7) cyc(1'b1);
        cyc(1'b0); cyc(1'b0);
        checks++; if (n_short !== 1) begin errors++; $display("FAIL b7_short: got %0d expected 1", n_short); end
        checks++; if (n_long !== 0)  begin errors++; $display("FAIL b7_long: got %0d expected 0", n_long); end
        clear_mon();
        repeat (7) cyc(1'b1);
        checks++; if (bus.long_press !== 1'b0) begin errors++; $display("FAIL b8_long_early: got %b expected 0", bus.long_press); end
        cyc(1'b1);
        checks++; if (bus.long_press !== 1'b1) begin errors++; $display("FAIL b8_long_strobe: got %b expected 1", bus.long_press); end
        checks++; if (bus.evt_count !== 8'd2)  begin errors++; $display("FAIL b8_evt_at_long: got %0d expected 2", bus.evt_count); end
        cyc(1'b0);
        checks++; if (bus.held !== 1'b0) begin errors++; $display("FAIL b8_held_rel: got %b expected 0", bus.held); end
        cyc(1'b0);
        checks++; if (n_short !== 0)          begin errors++; $display("FAIL b8_short: got %0d expected 0", n_short); end
        checks++; if (n_long !== 1)           begin errors++; $display("FAIL b8_long: got %0d expected 1", n_long); end
        checks++; if (bus.evt_count !== 8'd2) begin errors++; $display("FAIL b8_evt: got %0d expected 2", bus.evt_count); end
    endtask

    task automatic test_hold20();
        int base;
        do_reset(1'b0); cyc(1'b0); clear_mon();
        base = cycle;
        repeat (20) cyc(1'b1);
        checks++; if (n_long !== 1)          begin errors++; $display("FAIL h20_long: got %0d expected 1", n_long); end
        checks++; if (last_long !== base + 8) begin errors++; $display("FAIL h20_long_pos: got %0d expected %0d", last_long, base + 8); end
`ifdef BUTTON_EVENT_REPEAT_EN
        checks++; if (n_rep !== 3) begin errors++; $display("FAIL h20_rep_count: got %0d expected 3", n_rep); end
        if (rep_q.size() == 3) begin
            checks++; if (rep_q[0] !== base + 12) begin errors++; $display("FAIL h20_rep0: got %0d expected %0d", rep_q[0], base + 12); end
            checks++; if (rep_q[1] !== base + 16) begin errors++; $display("FAIL h20_rep1: got %0d expected %0d", rep_q[1], base + 16); end
            checks++; if (rep_q[2] !== base + 20) begin errors++; $display("FAIL h20_rep2: got %0d expected %0d", rep_q[2], base + 20); end
        end
`else
        checks++; if (n_rep !== 0) begin errors++; $display("FAIL h20_rep_count: got %0d expected 0", n_rep); end
`endif
        cyc(1'b0); cyc(1'b0);
        checks++; if (n_short !== 0)          begin errors++; $display("FAIL h20_short: got %0d expected 0", n_short); end
        checks++; if (bus.evt_count !== 8'd1) begin errors++; $display("FAIL h20_evt: got %0d expected 1", bus.evt_count); end
    endtask

    task automatic test_hold_through_reset();
        logic held_seen;
        held_seen = 1'b0;
        do_reset(1'b1); clear_mon();
        repeat (10) begin cyc(1'b1); held_seen = held_seen | bus.held; end
        cyc(1'b0);
        checks++; if (n_short + n_long + n_rep !== 0) begin errors++; $display("FAIL hr_events: got %0d expected 0", n_short + n_long + n_rep); end
        checks++; if (held_seen !== 1'b0)             begin errors++; $display("FAIL hr_held: got %b expected 0", held_seen); end
        cyc(1'b1); cyc(1'b1); cyc(1'b0);
        checks++; if (n_short !== 1)          begin errors++; $display("FAIL hr_short: got %0d expected 1", n_short); end
        checks++; if (bus.evt_count !== 8'd1) begin errors++; $display("FAIL hr_evt: got %0d expected 1", bus.evt_count); end
    endtask

    task automatic test_reset_in_held();
        do_reset(1'b0); cyc(1'b0);
        repeat (10) cyc(1'b1);
        checks++; if (bus.held !== 1'b1)      begin errors++; $display("FAIL rh_pre_held: got %b expected 1", bus.held); end
        checks++; if (bus.evt_count !== 8'd1) begin errors++; $display("FAIL rh_pre_evt: got %0d expected 1", bus.evt_count); end
        clear_mon();
        rst = 1'b1; cyc(1'b1); rst = 1'b0;
        checks++; if (bus.held !== 1'b0)         begin errors++; $display("FAIL rh_held: got %b expected 0", bus.held); end
        checks++; if (bus.evt_count !== 8'd0)    begin errors++; $display("FAIL rh_evt: got %0d expected 0", bus.evt_count); end
        checks++; if (bus.short_press !== 1'b0)  begin errors++; $display("FAIL rh_short: got %b expected 0", bus.short_press); end
        checks++; if (bus.long_press !== 1'b0)   begin errors++; $display("FAIL rh_long: got %b expected 0", bus.long_press); end
        checks++; if (bus.repeat_press !== 1'b0) begin errors++; $display("FAIL rh_repeat: got %b expected 0", bus.repeat_press); end
        repeat (3) cyc(1'b1);
        cyc(1'b0); cyc(1'b0);
        checks++; if (n_short + n_long + n_rep !== 0) begin errors++; $display("FAIL rh_after: got %0d expected 0", n_short + n_long + n_rep); end
    endtask

    task automatic test_wrap();
        do_reset(1'b0); cyc(1'b0); clear_mon();
        repeat (255) begin cyc(1'b1); cyc(1'b0); end
        checks++; if (bus.evt_count !== 8'd255) begin errors++; $display("FAIL wrap_255: got %0d expected 255", bus.evt_count); end
        cyc(1'b1); cyc(1'b0);
        checks++; if (bus.evt_count !== 8'd0) begin errors++; $display("FAIL wrap_0: got %0d expected 0", bus.evt_count); end
        checks++; if (n_short !== 256)        begin errors++; $display("FAIL wrap_short: got %0d expected 256", n_short); end
        checks++; if (n_long !== 0)           begin errors++; $display("FAIL wrap_long: got %0d expected 0", n_long); end
    endtask

    task automatic test_back_to_back();
        do_reset(1'b0); cyc(1'b0); clear_mon();
        cyc(1'b1); cyc(1'b1); cyc(1'b0);
        cyc(1'b1); cyc(1'b1); cyc(1'b0);
        checks++; if (n_short !== 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", n_short); end
        if (short_q.size() == 2) begin
            checks++; if (short_q[1] - short_q[0] !== 3) begin errors++; $display("FAIL b2b_gap: got %0d expected 3", short_q[1] - short_q[0]); end
        end
        checks++; if (bus.evt_count !== 8'd2) begin errors++; $display("FAIL b2b_evt: got %0d expected 2", bus.evt_count); end
    endtask

    initial begin
        rst = 1'b1;
        bus.btn_state = 1'b0;
        clear_mon();
        test_reset();
        test_short();
        test_long_boundary();
        test_hold20();
        test_hold_through_reset();
        test_reset_in_held();
        test_wrap();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/button_event_decoder.md
Name: button_event_decoder

Overview:
- Consumes the debounced, clock-synchronous level of one push-button, 1 = pressed.
- Classifies each press as a short press or a long press, with optional auto-repeat while the button stays held.
- Emits single-cycle event strobes and an event counter to downstream control logic, such as mode selection or digit increment.
- Sits directly after the per-button debouncer in the user-input path.

Parameters:
- LONG_CYCLES, 50_000_000: consecutive high samples, counting the rise sample, needed to declare a long press (0.5 s at 100 MHz). Must be >= 2.
- REPEAT_CYCLES, 10_000_000: high samples between auto-repeat strobes while held. Must be >= 1.
- CNT_W, 27: hold-counter width. Must satisfy 2^CNT_W > max(LONG_CYCLES, REPEAT_CYCLES).

Ports:
- clk  input  1  system clock; all logic on its rising edge
- rst  input  1  synchronous reset, active-high
- btn_state  input  1  debounced button level, already synchronous to clk
- short_press  output  1  one-cycle strobe when the button is released before the long threshold
- long_press  output  1  one-cycle strobe when the hold reaches LONG_CYCLES
- repeat_press  output  1  one-cycle auto-repeat strobe (see Optional Feature)
- held  output  1  level; 1 while a press is being tracked (PRESSED or HELD)
- evt_count  output  8  running count of short_press + long_press events; wraps

Behaviour:
- Single clock domain. All state and outputs are registered. Reset is synchronous and active-high.
- Reset values:
  - FSM = IDLE, cnt = 0
  - short_press = long_press = repeat_press = held = 0, evt_count = 0
  - prev_btn = 1
- Because prev_btn resets to 1, a button held through reset produces no events until it is released and pressed again.
- Edge detection:
  - prev_btn <= btn_state every cycle.
  - rise = btn_state & ~prev_btn.
- All three strobes default to 0 every cycle. Each is high for exactly one cycle per event.
- FSM states: IDLE, PRESSED, HELD.
- IDLE:
  - held = 0.
  - On rise: go to PRESSED, cnt <= 1, held <= 1. The rise sample counts as high sample 1.
- PRESSED, btn_state = 1:
  - If cnt == LONG_CYCLES-1: assert long_press next cycle, go to HELD, cnt <= 0, increment evt_count.
  - Otherwise: cnt <= cnt+1.
  - Net effect: long_press is high in the cycle after the LONG_CYCLES-th consecutive high sample.
- PRESSED, btn_state = 0:
  - Assert short_press next cycle, go to IDLE, cnt <= 0, held <= 0, increment evt_count.
  - A press of 1..LONG_CYCLES-1 high samples therefore gives exactly one short_press.
- HELD, btn_state = 1: count per the Optional Feature.
- HELD, btn_state = 0: go to IDLE, held <= 0, cnt <= 0. No short_press is generated.
- short_press and long_press are mutually exclusive for any single press.
- Every press produces exactly one of them, unless reset intervenes.
- evt_count:
  - 8-bit, increments once per short_press or long_press; repeat_press does not count.
  - Wraps 255 -> 0 with no saturation or flag.
- Reset mid-press (PRESSED or HELD):
  - Returns to the reset values immediately on the next edge; no strobe is issued.
  - If btn_state is still 1, the press is ignored until release and re-press.
- Back-to-back presses:
  - A rise sampled in the same cycle the FSM returns to IDLE is not lost.
  - Because prev_btn = 0 at that point, the rise is taken on the next edge.
  - The minimum supported gap is one low sample between presses.
- No combinational path from btn_state to any output. Latency from the deciding sample to its strobe is 1 cycle.

Optional Feature:
- Macro: BUTTON_EVENT_REPEAT_EN.
- Defined, HELD with btn_state = 1:
  - cnt increments each high sample.
  - When cnt == REPEAT_CYCLES-1: assert repeat_press next cycle and set cnt <= 0.
  - First repeat_press is the REPEAT_CYCLES-th high sample after the sample that fired long_press; subsequent strobes follow every REPEAT_CYCLES cycles.
- Not defined:
  - repeat_press is tied to 0.
  - cnt holds at 0 in HELD.
  - The REPEAT_CYCLES parameter is accepted but unused.

Test Plan (LONG_CYCLES = 8, REPEAT_CYCLES = 4, macro defined unless stated):
- Reset, then btn_state high for 3 samples, then low -> short_press high for 1 cycle, the cycle after the first low sample; long_press = 0; evt_count = 1; held high 3 cycles starting the cycle after the rise.
- High for exactly 7 samples -> short_press only. High for exactly 8 samples -> long_press 1 cycle after sample 8; no short_press on release; evt_count increments by 1.
- High for 20 samples (rise at sample 0) -> long_press after sample 7, repeat_press after samples 11, 15 and 19 (3 strobes); evt_count += 1. With the macro undefined: same long_press, repeat_press = 0 throughout.
- btn_state held high across rst deassert for 10 cycles, then low, then high 2 samples -> no events during the first hold; one short_press after the second press.
- rst asserted for 1 cycle while in HELD -> all outputs 0 on the next cycle, evt_count = 0, no strobe. After 256 short presses from reset, evt_count = 0 (wrap).
- Press pattern 2 high / 1 low / 2 high / 1 low -> two short_press strobes exactly 3 cycles apart; evt_count = 2.
